// File: rtl/alsu_arbiter.sv
// alsu_arbiter: two-requester round-robin front end for one shared ALSU.
// Supports lockable bursts so a requester can chain SHIFT/ROTATE beats.
// A tag pipeline routes each ALSU result back to its owner.
module alsu_arbiter #(
    parameter int ALSU_LAT = 2,
    parameter int LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_lock,
    input  logic [15:0] req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_lock,
    input  logic [15:0] req1_op,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [5:0]  rsp_out,
    output logic        rsp_err,
    output logic        alsu_rst,
    output logic [2:0]  alsu_opcode,
    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic        alsu_cin,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    output logic        alsu_direction,
    output logic        alsu_serial_in,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds
);

    typedef enum logic [2:0] {
        OP_OR     = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MULT   = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5
    } opcode_e;

    typedef enum logic {
        LOCK_OPEN,
        LOCK_HELD
    } lock_state_e;

    localparam logic [3:0]  LOCK_LIMIT = 4'(LOCK_MAX);
    // OR with bypass_A and A=0: drives a harmless zero result.
    localparam logic [15:0] PARK_OP    = 16'h0008;

    lock_state_e state, state_next;
    logic        owner, owner_next;
    logic        ptr, ptr_next;
    logic [3:0]  cnt, cnt_next;
    logic [3:0]  beat_cnt;

    logic        rst_q;
    logic        accept_ok;
    logic        xfer;
    logic        xid;
    logic        xlock;
    logic [15:0] xop;
    logic        xerr;
    logic [2:0]  xopc;

    logic [15:0]       issue_op;
    logic [ALSU_LAT:0] tag_v;
    logic [ALSU_LAT:0] tag_id;
    logic [ALSU_LAT:0] tag_err;

    logic unused_leds;
    assign unused_leds = ^alsu_leds;

    // No accepts while the ALSU reset pulse is still pending, so no op is wiped.
    assign accept_ok = rst & rst_q;

    assign {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_red_op_A, alsu_red_op_B,
            alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in} = issue_op;

    // ALSU reset follows rst and is stretched one cycle past its release.
    always_ff @(posedge clk) begin
        rst_q    <= rst;
        alsu_rst <= ~rst | ~rst_q;
    end

    // Arbitration state: lock owner/state, beat counter, round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOCK_OPEN;
            owner <= 1'b0;
            ptr   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            ptr   <= ptr_next;
            cnt   <= cnt_next;
        end
    end

    // Grant selection and lock/pointer next-state.
    always_comb begin
        state_next = state;
        owner_next = owner;
        ptr_next   = ptr;
        cnt_next   = cnt;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        if (accept_ok) begin
            if (state == LOCK_HELD) begin
                if (owner) req1_ready = req1_valid;
                else       req0_ready = req0_valid;
            end else if (ptr) begin
                req1_ready = req1_valid;
                req0_ready = req0_valid & ~req1_valid;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid & ~req0_valid;
            end
        end

        xfer     = req0_ready | req1_ready;
        xid      = req1_ready;
        xop      = req1_ready ? req1_op : req0_op;
        xlock    = req1_ready ? req1_lock : req0_lock;
        xopc     = xop[15:13];
        xerr     = (xopc > OP_ROTATE) ||
                   ((xop[5] | xop[4]) && (xopc != OP_OR) && (xopc != OP_XOR));
        beat_cnt = ((state == LOCK_HELD) ? cnt : 4'd0) + 4'd1;

        // A beat that hits the limit releases regardless of its own lock bit.
        if (xfer) begin
            if (xlock && (beat_cnt != LOCK_LIMIT)) begin
                state_next = LOCK_HELD;
                owner_next = xid;
                cnt_next   = beat_cnt;
            end else begin
                state_next = LOCK_OPEN;
                cnt_next   = '0;
                ptr_next   = ~xid;
            end
        end
    end

    // Issue register: granted op for exactly one cycle, otherwise the park op.
    always_ff @(posedge clk) begin
        if (!rst)       issue_op <= PARK_OP;
        else if (xfer)  issue_op <= xop;
        else            issue_op <= PARK_OP;
    end

    // Tag pipeline: entry 0 tracks the issue register, entry ALSU_LAT exits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_v   <= '0;
            tag_id  <= '0;
            tag_err <= '0;
        end else begin
            tag_v   <= {tag_v[ALSU_LAT-1:0], xfer};
            tag_id  <= {tag_id[ALSU_LAT-1:0], xid};
            tag_err <= {tag_err[ALSU_LAT-1:0], xerr};
        end
    end

    // Response capture when a tag leaves the pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_out   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= tag_v[ALSU_LAT];
            if (tag_v[ALSU_LAT]) begin
                rsp_id  <= tag_id[ALSU_LAT];
                rsp_out <= alsu_out;
                rsp_err <= tag_err[ALSU_LAT];
            end
        end
    end

endmodule

// File: tb/tb_alsu_arbiter.sv
// tb_alsu_arbiter: directed bench for alsu_arbiter with a behavioural
// 2-stage ALSU model attached to the alsu_* port.
module tb_alsu_arbiter;

    localparam int ALSU_LAT = 2;
    localparam int LOCK_MAX = 8;
    localparam logic [15:0] PARK = 16'h0008;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_lock;
    logic [15:0] req0_op;
    logic        req1_valid, req1_ready, req1_lock;
    logic [15:0] req1_op;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [5:0]  rsp_out;
    logic        alsu_rst;
    logic [2:0]  alsu_opcode, alsu_A, alsu_B;
    logic        alsu_cin, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic        alsu_direction, alsu_serial_in;
    logic [5:0]  alsu_out;
    logic [15:0] alsu_leds;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic       id;
        logic       err;
        logic [5:0] out;
    } rsp_t;
    rsp_t rq[$];

    always #5 clk = ~clk;

    alsu_arbiter #(.ALSU_LAT(ALSU_LAT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_err(rsp_err),
        .alsu_rst(alsu_rst), .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
        .alsu_cin(alsu_cin), .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_direction(alsu_direction), .alsu_serial_in(alsu_serial_in),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds)
    );

    // Behavioural ALSU: inputs registered, then result registered (2 cycles).
    logic [15:0] m_in;
    logic [5:0]  m_out;

    function automatic logic [5:0] alsu_fn(input logic [15:0] op, input logic [5:0] prev);
        logic [2:0] opc, a, b;
        logic       cin, ra, rb, ba, bb, dir, sin;
        logic [5:0] sa, sb;
        {opc, a, b, cin, ra, rb, ba, bb, dir, sin} = op;
        sa = {{3{a[2]}}, a};
        sb = {{3{b[2]}}, b};
        if (opc > 3'd5 || ((ra || rb) && opc > 3'd1)) return 6'd0;
        if (ba) return sa;
        if (bb) return sb;
        case (opc)
            3'd0:    return ra ? {5'd0, |a} : rb ? {5'd0, |b} : (sa | sb);
            3'd1:    return ra ? {5'd0, ^a} : rb ? {5'd0, ^b} : (sa ^ sb);
            3'd2:    return sa + sb + {5'd0, cin};
            3'd3:    return sa * sb;
            3'd4:    return dir ? {prev[4:0], sin} : {sin, prev[5:1]};
            default: return dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (alsu_rst) begin
            m_in  <= 16'd0;
            m_out <= 6'd0;
        end else begin
            m_in  <= alsu_vec();
            m_out <= alsu_fn(m_in, m_out);
        end
    end
    assign alsu_out  = m_out;
    assign alsu_leds = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rsp_valid === 1'b1)
            rq.push_back('{cyc: cyc, id: rsp_id, err: rsp_err, out: rsp_out});

    function automatic logic [15:0] alsu_vec();
        return {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_red_op_A, alsu_red_op_B,
                alsu_bypass_A, alsu_bypass_B, alsu_direction, alsu_serial_in};
    endfunction

    function automatic logic [15:0] mk_op(input logic [2:0] opc, input logic [2:0] a,
                                          input logic [2:0] b, input logic cin = 0,
                                          input logic ra = 0, input logic rb = 0,
                                          input logic ba = 0, input logic bb = 0,
                                          input logic dir = 0, input logic sin = 0);
        return {opc, a, b, cin, ra, rb, ba, bb, dir, sin};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_rsp(input string tag, input logic id, input logic [5:0] out,
                           input logic err, input logic chk_out, input int exp_cyc);
        rsp_t r;
        for (int n = 0; n < 12 && rq.size() == 0; n++) step();
        chk({tag, "_present"}, (rq.size() > 0), 1);
        if (rq.size() > 0) begin
            r = rq.pop_front();
            chk({tag, "_cycle"}, r.cyc, exp_cyc);
            chk({tag, "_id"}, r.id, id);
            chk({tag, "_err"}, r.err, err);
            if (chk_out) chk({tag, "_out"}, r.out, out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xc[16];
        logic eid[4];

        // Reset with a pending request: nothing may be accepted.
        rst = 1'b0;
        req0_valid = 1'b1; req0_lock = 1'b0; req0_op = mk_op(3'd2, 3'd3, 3'd2, 1'b1);
        req1_valid = 1'b0; req1_lock = 1'b0; req1_op = 16'd0;
        step(); step();
        chk("rst_alsu_rst", alsu_rst, 1);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_park", alsu_vec(), PARK);
        req0_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("hold_alsu_rst", alsu_rst, 1);
        step();
        chk("release_alsu_rst", alsu_rst, 0);
        repeat (3) step();
        chk("idle_park", alsu_vec(), PARK);
        chk("idle_no_rsp", rq.size(), 0);

        // Single ADD 3+2+1 from requester 0.
        req0_valid = 1'b1;
        #1;
        chk("add_ready0", req0_ready, 1);
        chk("add_ready1", req1_ready, 0);
        step(); xc[0] = cyc;
        req0_valid = 1'b0;
        chk("add_issue", alsu_vec(), 16'b010_011_010_1000000);
        step();
        chk("add_then_park", alsu_vec(), PARK);
        get_rsp("add", 1'b0, 6'd6, 1'b0, 1'b1, xc[0] + 3);

        // Both valid, no lock: pointer sits at 1 after the ADD, so 1,0,1,0.
        req0_op = mk_op(3'd3, 3'b110, 3'b011);
        req1_op = mk_op(3'd3, 3'b110, 3'b011);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eid[i] = (i % 2 == 0);
            #1;
            chk("alt_ready0", req0_ready, !eid[i]);
            chk("alt_ready1", req1_ready, eid[i]);
            step(); xc[i] = cyc;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) get_rsp("alt", eid[i], 6'b111010, 1'b0, 1'b1, xc[i] + 3);

        // Locked burst from requester 1: ADD 1, SHIFT-left x2 -> 1, 3, 7.
        req0_op = mk_op(3'd2, 3'd1, 3'd1); req0_valid = 1'b1;
        req1_op = mk_op(3'd2, 3'd1, 3'd0); req1_lock = 1'b1; req1_valid = 1'b1;
        #1;
        chk("burst1_ready1", req1_ready, 1);
        chk("burst1_ready0", req0_ready, 0);
        step(); xc[0] = cyc;
        req1_op = mk_op(3'd4, 3'd0, 3'd0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        #1;
        chk("burst2_ready1", req1_ready, 1);
        chk("burst2_ready0", req0_ready, 0);
        step(); xc[1] = cyc;
        req1_lock = 1'b0;
        #1;
        chk("burst3_ready1", req1_ready, 1);
        chk("burst3_ready0", req0_ready, 0);
        step(); xc[2] = cyc;
        req1_valid = 1'b0;
        #1;
        chk("after_burst_ready0", req0_ready, 1);
        step(); xc[3] = cyc;
        req0_valid = 1'b0;
        get_rsp("burst_b1", 1'b1, 6'd1, 1'b0, 1'b1, xc[0] + 3);
        get_rsp("burst_b2", 1'b1, 6'd3, 1'b0, 1'b1, xc[1] + 3);
        get_rsp("burst_b3", 1'b1, 6'd7, 1'b0, 1'b1, xc[2] + 3);
        get_rsp("burst_r0", 1'b0, 6'd2, 1'b0, 1'b1, xc[3] + 3);

        // Requester 0 holds lock with pointer at 1: 8 beats, then forced release.
        req0_op = mk_op(3'd2, 3'd1, 3'd1); req0_lock = 1'b1; req0_valid = 1'b1;
        #1;
        chk("lk_first_ready0", req0_ready, 1);
        step(); xc[0] = cyc;
        req1_op = mk_op(3'd2, 3'd2, 3'd1); req1_lock = 1'b1; req1_valid = 1'b1;
        for (int i = 1; i < 8; i++) begin
            #1;
            chk("lk_ready0", req0_ready, 1);
            chk("lk_ready1", req1_ready, 0);
            step(); xc[i] = cyc;
        end
        #1;
        chk("forced_rel_ready1", req1_ready, 1);
        chk("forced_rel_ready0", req0_ready, 0);
        step(); xc[8] = cyc;
        // Requester 1 now owns the lock and goes idle for one cycle.
        req1_valid = 1'b0;
        #1;
        chk("own_idle_ready0", req0_ready, 0);
        chk("own_idle_ready1", req1_ready, 0);
        step();
        chk("own_idle_park", alsu_vec(), PARK);
        req1_op = mk_op(3'd2, 3'd2, 3'd2); req1_lock = 1'b0; req1_valid = 1'b1;
        #1;
        chk("own_back_ready1", req1_ready, 1);
        chk("own_back_ready0", req0_ready, 0);
        step(); xc[9] = cyc;
        req1_valid = 1'b0; req0_lock = 1'b0;
        #1;
        chk("unlock_ready0", req0_ready, 1);
        step(); xc[10] = cyc;
        req0_valid = 1'b0;
        for (int i = 0; i < 8; i++) get_rsp("lk_r0", 1'b0, 6'd2, 1'b0, 1'b1, xc[i] + 3);
        get_rsp("lk_r1a", 1'b1, 6'd3, 1'b0, 1'b1, xc[8] + 3);
        get_rsp("lk_r1b", 1'b1, 6'd4, 1'b0, 1'b1, xc[9] + 3);
        get_rsp("lk_r0_last", 1'b0, 6'd2, 1'b0, 1'b1, xc[10] + 3);

        // Error classification: opcode 7, reduction with ADD, reduction with XOR.
        req0_op = mk_op(3'd7, 3'd1, 3'd1); req0_valid = 1'b1;
        step(); xc[0] = cyc; req0_valid = 1'b0;
        req1_op = mk_op(3'd2, 3'd1, 3'd1, 0, 1'b1); req1_valid = 1'b1;
        step(); xc[1] = cyc; req1_valid = 1'b0;
        req0_op = mk_op(3'd1, 3'd0, 3'b111, 0, 0, 1'b1); req0_valid = 1'b1;
        step(); xc[2] = cyc; req0_valid = 1'b0;
        get_rsp("err_op7", 1'b0, 6'd0, 1'b1, 1'b0, xc[0] + 3);
        get_rsp("err_red_add", 1'b1, 6'd0, 1'b1, 1'b0, xc[1] + 3);
        get_rsp("ok_red_xor", 1'b0, 6'd1, 1'b0, 1'b1, xc[2] + 3);

        // Reset with two ops in flight: neither may produce a response.
        req1_op = mk_op(3'd2, 3'd1, 3'd1); req1_valid = 1'b1;
        step(); req1_valid = 1'b0;
        req0_op = mk_op(3'd2, 3'd1, 3'd2); req0_valid = 1'b1;
        step(); req0_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("flush_alsu_rst", alsu_rst, 1);
        chk("flush_park", alsu_vec(), PARK);
        chk("flush_rsp_valid", rsp_valid, 0);
        step();
        rst = 1'b1;
        repeat (8) step();
        chk("flush_no_rsp", rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
